// File: rtl/signal_window_pkg.sv
// Shared constants and helpers for the signal_window_sum slice.
//   SW_IN_WIDTH_DEF : default sample width
//   SW_DEPTH_DEF    : default window length (power of two)
//   sw_out_width()  : full-precision sum width for a given sample width/depth
package signal_window_pkg;

  localparam int unsigned SW_IN_WIDTH_DEF = 32;
  localparam int unsigned SW_DEPTH_DEF    = 8;

  // Summing 2^k values of in_w bits needs in_w+k bits to never overflow.
  function automatic int unsigned sw_out_width(input int unsigned in_w,
                                               input int unsigned depth);
    return in_w + 32'($clog2(depth));
  endfunction

endpackage

// File: rtl/signal_window_buf.sv
// Circular sample buffer for the sliding window.
// Exposes the entry at the write pointer combinationally, i.e. the sample that
// the next write will overwrite (the one leaving the window).
// Ports:
//   CLK       : clock, rising edge
//   RESET     : asynchronous active-high reset (clears write pointer only)
//   WE        : write strobe; stores WDATA and advances the pointer
//   WDATA     : sample to store
//   RDATA_OLD : current contents of the entry about to be overwritten
module signal_window_buf
  import signal_window_pkg::*;
#(
  parameter int unsigned IN_WIDTH = SW_IN_WIDTH_DEF,
  parameter int unsigned DEPTH    = SW_DEPTH_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                WE,
  input  logic [IN_WIDTH-1:0] WDATA,
  output logic [IN_WIDTH-1:0] RDATA_OLD
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]    r_wr_ptr;
  logic [IN_WIDTH-1:0] r_mem [DEPTH];

  // Write pointer; DEPTH is a power of two so the wrap is the natural overflow.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
    end else if (WE) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
    end
  end

  // Storage is not reset: the top never uses an entry before it is written.
  always_ff @(posedge CLK) begin
    if (WE) begin
      r_mem[r_wr_ptr] <= WDATA;
    end
  end

  assign RDATA_OLD = r_mem[r_wr_ptr];

endmodule

// File: rtl/signal_window_sum.sv
// Sliding-window sum of the last DEPTH valid samples, one result per valid
// input once the window has filled, latency one cycle, no backpressure.
// Optional feature macro: SIGNAL_WINDOW_AVG_EN -- when defined, OUT_VALUE is
// the truncated mean (sum >> log2(DEPTH)); the internal sum stays full width.
// Ports:
//   CLK       : clock, rising edge
//   RESET     : asynchronous active-high reset
//   IN_VALUE  : sample, meaningful only when IN_VALID=1
//   IN_VALID  : sample strobe
//   OUT_VALUE : window sum (or mean), holds between results
//   OUT_VALID : one-cycle strobe qualifying OUT_VALUE
module signal_window_sum
  import signal_window_pkg::*;
#(
  parameter int unsigned IN_WIDTH = SW_IN_WIDTH_DEF,
  parameter int unsigned DEPTH    = SW_DEPTH_DEF
) (
  input  logic                                       CLK,
  input  logic                                       RESET,
  input  logic [IN_WIDTH-1:0]                        IN_VALUE,
  input  logic                                       IN_VALID,
  output logic [sw_out_width(IN_WIDTH, DEPTH)-1:0]   OUT_VALUE,
  output logic                                       OUT_VALID
);

  localparam int unsigned OUT_WIDTH  = sw_out_width(IN_WIDTH, DEPTH);
  localparam int unsigned LOG2_DEPTH = $clog2(DEPTH);
  localparam int unsigned FILL_W     = LOG2_DEPTH + 1;

  logic [FILL_W-1:0]    r_fill;
  logic [OUT_WIDTH-1:0] r_sum;

  logic [IN_WIDTH-1:0]  w_rdata_old;
  logic                 w_full;
  logic [IN_WIDTH-1:0]  w_old;
  logic [FILL_W-1:0]    w_fill_next;
  logic                 w_window_done;
  logic [OUT_WIDTH-1:0] w_sum_next;
  logic [OUT_WIDTH-1:0] w_out_next;

  signal_window_buf #(
    .IN_WIDTH (IN_WIDTH),
    .DEPTH    (DEPTH)
  ) u_buf (
    .CLK       (CLK),
    .RESET     (RESET),
    .WE        (IN_VALID),
    .WDATA     (IN_VALUE),
    .RDATA_OLD (w_rdata_old)
  );

  // A sample only leaves the window once the window is full; before that the
  // buffer slot holds stale data from before reset and must be ignored.
  assign w_full        = (r_fill == FILL_W'(DEPTH));
  assign w_old         = w_full ? w_rdata_old : '0;
  assign w_fill_next   = w_full ? r_fill : (r_fill + FILL_W'(1));
  assign w_window_done = (w_fill_next == FILL_W'(DEPTH));

  // Add-then-subtract wraps modulo 2^OUT_WIDTH; the final value always fits.
  assign w_sum_next = r_sum + OUT_WIDTH'(IN_VALUE) - OUT_WIDTH'(w_old);

`ifdef SIGNAL_WINDOW_AVG_EN
  assign w_out_next = w_sum_next >> LOG2_DEPTH;
`else
  assign w_out_next = w_sum_next;
`endif

  // Window state and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_fill    <= '0;
      r_sum     <= '0;
      OUT_VALUE <= '0;
      OUT_VALID <= 1'b0;
    end else if (IN_VALID) begin
      r_fill    <= w_fill_next;
      r_sum     <= w_sum_next;
      OUT_VALUE <= w_out_next;
      OUT_VALID <= w_window_done;
    end else begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule
